// File: rtl/axi_burst_master_port.sv
// AXI4 master port: converts one CPU-side request (single beat or INCR burst,
// read or write) into a complete AXI transaction, one transaction in flight.
module axi_burst_master_port #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int LEN_W     = 4,
    parameter int MASTER_ID = 0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [LEN_W-1:0]      req_len,

    input  logic                  wd_valid,
    input  logic [DATA_W-1:0]     wd_data,
    input  logic [DATA_W/8-1:0]   wd_strb,
    output logic                  wd_ready,

    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  rd_last,

    output logic                  rsp_valid,
    output logic                  rsp_err,

    output logic [ID_W-1:0]       ARID,
    output logic [ADDR_W-1:0]     ARADDR,
    output logic [LEN_W-1:0]      ARLEN,
    output logic [2:0]            ARSIZE,
    output logic [1:0]            ARBURST,
    output logic                  ARVALID,
    input  logic                  ARREADY,

    input  logic [ID_W-1:0]       RID,
    input  logic [DATA_W-1:0]     RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RLAST,
    input  logic                  RVALID,
    output logic                  RREADY,

    output logic [ID_W-1:0]       AWID,
    output logic [ADDR_W-1:0]     AWADDR,
    output logic [LEN_W-1:0]      AWLEN,
    output logic [2:0]            AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,

    output logic [DATA_W-1:0]     WDATA,
    output logic [DATA_W/8-1:0]   WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,

    input  logic [ID_W-1:0]       BID,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY
);

    localparam int STRB_W = DATA_W / 8;
    localparam int SIZE   = $clog2(STRB_W);
    localparam int CHK_W  = LEN_W + 14;

    typedef enum logic [2:0] {IDLE, AR, R, WR, B, ERR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic              we_q;
    logic [LEN_W-1:0]  count;
    logic              err;
    logic              aw_done;
    logic              w_active;

    logic [ADDR_W-1:0] addr_al;
    logic [CHK_W-1:0]  span_end;
    logic              crosses_4k;
    logic              r_hs;
    logic              w_hs;
    logic              aw_hs;
    logic              last_beat;

    assign ARID    = ID_W'(MASTER_ID);
    assign AWID    = ID_W'(MASTER_ID);
    assign ARBURST = 2'b01;
    assign AWBURST = 2'b01;
    assign ARSIZE  = 3'(SIZE);
    assign AWSIZE  = 3'(SIZE);
    assign ARADDR  = addr_q;
    assign AWADDR  = addr_q;
    assign ARLEN   = len_q;
    assign AWLEN   = len_q;

    assign rd_valid = RVALID && RREADY;
    assign rd_data  = RDATA;
    assign rd_last  = RLAST && RREADY;

    // Write data streams straight through while the burst still owes beats
    assign WVALID   = wd_valid && w_active;
    assign WDATA    = wd_data;
    assign WSTRB    = wd_strb;
    assign WLAST    = w_active && last_beat;
    assign wd_ready = WREADY && w_active;

    assign r_hs      = RVALID && RREADY;
    assign w_hs      = WVALID && WREADY;
    assign aw_hs     = AWVALID && AWREADY;
    assign last_beat = (count == len_q);

    // A burst whose last byte lands past the end of its 4KB page is refused
    assign addr_al    = req_addr & ~ADDR_W'(STRB_W - 1);
    assign span_end   = CHK_W'(addr_al[11:0]) + ((CHK_W'(req_len) + CHK_W'(1)) << SIZE);
    assign crosses_4k = span_end > CHK_W'(4096);

    logic unused_inputs;
    assign unused_inputs = ^{RID, BID, RRESP[0], BRESP[0], we_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            len_q     <= '0;
            we_q      <= 1'b0;
            count     <= '0;
            err       <= 1'b0;
            aw_done   <= 1'b0;
            w_active  <= 1'b0;
            req_ready <= 1'b0;
            ARVALID   <= 1'b0;
            RREADY    <= 1'b0;
            AWVALID   <= 1'b0;
            BREADY    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        addr_q    <= addr_al;
                        len_q     <= req_len;
                        we_q      <= req_we;
                        count     <= '0;
                        err       <= 1'b0;
                        aw_done   <= 1'b0;
                        if (crosses_4k) begin
                            state <= ERR;
                        end else if (req_we) begin
                            state    <= WR;
                            AWVALID  <= 1'b1;
                            w_active <= 1'b1;
                        end else begin
                            state   <= AR;
                            ARVALID <= 1'b1;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ERR: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    state     <= IDLE;
                end
                AR: begin
                    if (ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= R;
                    end
                end
                R: begin
                    // A mismatch between RLAST and the expected beat count is an error
                    if (r_hs) begin
                        if (RLAST || last_beat) begin
                            RREADY    <= 1'b0;
                            rsp_valid <= 1'b1;
                            rsp_err   <= err | RRESP[1] | (RLAST != last_beat);
                            state     <= IDLE;
                        end else begin
                            count <= count + LEN_W'(1);
                            err   <= err | RRESP[1];
                        end
                    end
                end
                WR: begin
                    if (aw_hs) begin
                        AWVALID <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        if (last_beat) w_active <= 1'b0;
                        else           count    <= count + LEN_W'(1);
                    end
                    if ((aw_done || aw_hs) && (!w_active || (w_hs && last_beat))) begin
                        BREADY <= 1'b1;
                        state  <= B;
                    end
                end
                B: begin
                    if (BVALID) begin
                        BREADY    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= BRESP[1];
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
